// File: rtl/dut3_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dut3_chk_pkg
// Description : Shared types and constants for the 3-input vector checker:
//               sweep state encoding, vector/index/counter widths and the
//               expected truth tables of the known test circuits.
// Revision    : 1.0 - initial release
// ============================================================================
package dut3_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } chk_state_t;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int CNT_W       = 4;

    // Expected y indexed by {a,b,c}. NAND(NOR(a,b), NOR(b,c)) reduces to
    // a|b|c, so only vector 000 expects a 0.
    localparam logic [NUM_VECTORS-1:0] c_EXP_NOR_NOR_NAND = 8'hFE;

endpackage
`default_nettype wire

// File: rtl/dut3_vector_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : dut3_vector_checker_if
// Description : Bundle between the vector checker and the harness.
//               Stimulus side : a, b, c (to circuit under test), y (back).
//               Control side  : start in; busy, done, pass, err_count,
//                               fail_valid, first_fail_idx out.
//               master = checker, slave = harness / circuit under test.
// Revision    : 1.0 - initial release
// ============================================================================
interface dut3_vector_checker_if;
    import dut3_chk_pkg::*;

    logic             start;
    logic             a;
    logic             b;
    logic             c;
    logic             y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic             fail_valid;
    logic [IDX_W-1:0] first_fail_idx;

    modport master (
        input  start, y,
        output a, b, c, busy, done, pass, err_count, fail_valid, first_fail_idx
    );

    modport slave (
        output start, y,
        input  a, b, c, busy, done, pass, err_count, fail_valid, first_fail_idx
    );

endinterface
`default_nettype wire

// File: rtl/dut3_vector_checker_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : dut3_vector_checker_settle_timer
// Description : Loadable down-counter with a zero flag. Load wins over
//               decrement; the count stops at zero.
// Ports       : clk, rst_n (async active-low), i_load, i_load_val,
//               i_dec (decrement enable), o_zero (count == 0)
// Revision    : 1.0 - initial release
// ============================================================================
module dut3_vector_checker_settle_timer #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_val,
    input  wire logic             i_dec,
    output logic                  o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/dut3_vector_checker.sv
`default_nettype none
// ============================================================================
// Module      : dut3_vector_checker
// Description : Sweeps all 8 vectors {a,b,c} into a combinational circuit,
//               holds each for SETTLE_CYCLES clocks, samples y for one
//               cycle and compares it with EXP_TABLE. Counts mismatches,
//               records the first failing vector and reports pass/fail.
// Ports       : clk, rst_n (async active-low)
//               bus (master): start in, y in; a/b/c, busy, done, pass,
//               err_count, fail_valid, first_fail_idx out (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module dut3_vector_checker
    import dut3_chk_pkg::*;
#(
    parameter int unsigned            SETTLE_CYCLES = 2,   // legal 1..15
    parameter logic [NUM_VECTORS-1:0] EXP_TABLE     = c_EXP_NOR_NOR_NAND
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    dut3_vector_checker_if.master bus
);

    localparam logic [CNT_W-1:0] c_RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] c_ERR_MAX  = CNT_W'(NUM_VECTORS);

    chk_state_t       r_state, w_state_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;
    logic             r_pass, w_pass_next;
    logic [CNT_W-1:0] r_err, w_err_next;
    logic             r_fail_valid, w_fail_valid_next;
    logic [IDX_W-1:0] r_first_fail, w_first_fail_next;

    logic w_timer_load;
    logic w_timer_dec;
    logic w_timer_zero;
    logic w_mismatch;

    // y is only meaningful in SAMPLE; the vector has been stable since the
    // start of SETTLE, so the combinational circuit has settled.
    assign w_mismatch = (bus.y != EXP_TABLE[r_idx]);

    dut3_vector_checker_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_timer_load),
        .i_load_val (c_RELOAD),
        .i_dec      (w_timer_dec),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_pass       <= w_pass_next;
            r_err        <= w_err_next;
            r_fail_valid <= w_fail_valid_next;
            r_first_fail <= w_first_fail_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_busy_next       = r_busy;
        w_done_next       = 1'b0;
        w_pass_next       = r_pass;
        w_err_next        = r_err;
        w_fail_valid_next = r_fail_valid;
        w_first_fail_next = r_first_fail;
        w_timer_load      = 1'b0;
        w_timer_dec       = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_next      = SETTLE;
                    w_idx_next        = '0;
                    w_busy_next       = 1'b1;
                    w_pass_next       = 1'b0;
                    w_err_next        = '0;
                    w_fail_valid_next = 1'b0;
                    w_first_fail_next = '0;
                    w_timer_load      = 1'b1;
                end
            end

            SETTLE: begin
                w_timer_dec = 1'b1;
                if (w_timer_zero) begin
                    w_state_next = SAMPLE;
                end
            end

            SAMPLE: begin
                if (w_mismatch) begin
                    if (r_err != c_ERR_MAX) begin
                        w_err_next = r_err + 1'b1;
                    end
                    if (!r_fail_valid) begin
                        w_fail_valid_next = 1'b1;
                        w_first_fail_next = r_idx;
                    end
                end
                if (r_idx == c_LAST_IDX) begin
                    // Vector stays at 111 in DONE; pass folds in this
                    // cycle's compare since r_err has not yet absorbed it.
                    w_state_next = DONE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                    w_pass_next  = (r_err == '0) && !w_mismatch;
                end else begin
                    w_state_next = SETTLE;
                    w_idx_next   = r_idx + 1'b1;
                    w_timer_load = 1'b1;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // The vector index is the stimulus itself: a is its MSB.
    assign bus.a              = r_idx[2];
    assign bus.b              = r_idx[1];
    assign bus.c              = r_idx[0];
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.err_count      = r_err;
    assign bus.fail_valid     = r_fail_valid;
    assign bus.first_fail_idx = r_first_fail;

endmodule
`default_nettype wire
